// File: rtl/empaquetador_byte.sv
// Packs four 2-bit symbols MSB-first into bytes and queues them in a FWFT FIFO of DEPTH entries.
// Optional macro PARIDAD_EN adds a stored even-parity bit per entry, presented on parity_out.
module empaquetador_byte #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_L,
    input  logic [1:0] data_in,
    input  logic       valid_in,
    input  logic       pop,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       full,
    output logic       empty,
    output logic       overflow
`ifdef PARIDAD_EN
    ,
    output logic       parity_out
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
`ifdef PARIDAD_EN
    localparam int EW = 9;
`else
    localparam int EW = 8;
`endif

    localparam logic [0:0] ESPERA  = 1'b0;
    localparam logic [0:0] ACUMULA = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [5:0]    part_q, part_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [EW-1:0] mem_q [DEPTH];

    logic          byte_done;
    logic          do_pop;
    logic          do_push;
    logic [7:0]    new_byte;
    logic [EW-1:0] new_entry;
    logic [EW-1:0] head;

    // The first three symbols live in part_q; the fourth joins straight from data_in.
    assign new_byte  = {part_q, data_in};
`ifdef PARIDAD_EN
    assign new_entry = {^new_byte, new_byte};
`else
    assign new_entry = new_byte;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        part_d     = part_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        byte_done = valid_in && (cnt_q == 2'd3);
        do_pop    = pop && (count_q != '0);
        // A full FIFO still takes the new byte when the head leaves on the same edge.
        do_push   = byte_done && ((count_q != DEPTH_C) || do_pop);

        if (valid_in) begin
            cnt_d  = cnt_q + 2'd1;
            part_d = byte_done ? '0 : {part_q[3:0], data_in};
            case (state_q)
                ESPERA:  state_d = ACUMULA;
                ACUMULA: if (byte_done) state_d = ESPERA;
                default: state_d = ESPERA;
            endcase
        end

        if (byte_done && !do_push) overflow_d = 1'b1;

        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;

        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state_q    <= ESPERA;
            cnt_q      <= '0;
            part_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            part_q     <= part_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            if (do_push) mem_q[wr_ptr_q] <= new_entry;
        end
    end

    assign head      = mem_q[rd_ptr_q];
    assign empty     = (count_q == '0);
    assign full      = (count_q == DEPTH_C);
    assign valid_out = !empty;
    assign overflow  = overflow_q;
    assign data_out  = empty ? 8'h00 : head[7:0];
`ifdef PARIDAD_EN
    assign parity_out = empty ? 1'b0 : head[8];
`endif

endmodule

// File: tb/tb_empaquetador_byte.sv
// Bench for empaquetador_byte: vector table, directed corner sequences and random traffic
// against a queue-based reference model.
module tb_empaquetador_byte;

    localparam int DEPTH = 4;

    logic       clk;
    logic       reset_L;
    logic [1:0] data_in;
    logic       valid_in;
    logic       pop;
    logic [7:0] data_out;
    logic       valid_out;
    logic       full;
    logic       empty;
    logic       overflow;
`ifdef PARIDAD_EN
    logic       parity_out;
`else
    logic       parity_out;
    assign parity_out = 1'b0;
`endif

    empaquetador_byte #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .pop       (pop),
        .data_out  (data_out),
        .valid_out (valid_out),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow)
`ifdef PARIDAD_EN
        ,
        .parity_out(parity_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: bytes in a queue, partial byte as an integer accumulated base-4.
    int unsigned mq[$];
    int          m_nsym = 0;
    int unsigned m_part = 0;
    logic        m_ovf  = 1'b0;

    typedef struct {
        logic       rl;
        logic [1:0] d;
        logic       v;
        logic       p;
        logic [7:0] ed;
        logic       ev;
        logic       ef;
        logic       ee;
        logic       eo;
    } vec_t;

    vec_t tbl[16];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] dut_vec();
        return {3'b0, data_out, valid_out, full, empty, overflow, parity_out};
    endfunction

    function automatic logic [15:0] model_vec();
        logic [7:0] hd;
        logic       par;
        hd  = (mq.size() > 0) ? 8'(mq[0]) : 8'h00;
`ifdef PARIDAD_EN
        par = ^hd;
`else
        par = 1'b0;
`endif
        return {3'b0, hd, mq.size() > 0, mq.size() == DEPTH, mq.size() == 0, m_ovf, par};
    endfunction

    task automatic model_edge(input logic rl, input logic [1:0] d, input logic v, input logic p);
        logic        eff_pop;
        logic        done;
        int unsigned b;
        if (!rl) begin
            mq.delete();
            m_nsym = 0;
            m_part = 0;
            m_ovf  = 1'b0;
        end else begin
            eff_pop = p && (mq.size() > 0);
            done    = 1'b0;
            b       = 0;
            if (v) begin
                m_part = m_part * 4 + d;
                m_nsym++;
                if (m_nsym == 4) begin
                    done   = 1'b1;
                    b      = m_part;
                    m_nsym = 0;
                    m_part = 0;
                end
            end
            if (done && mq.size() == DEPTH && !eff_pop) begin
                m_ovf = 1'b1;
                done  = 1'b0;
            end
            if (eff_pop) mq.delete(0);
            if (done) mq.push_back(b);
        end
    endtask

    task automatic step(input logic rl, input logic [1:0] d, input logic v, input logic p);
        reset_L  = rl;
        data_in  = d;
        valid_in = v;
        pop      = p;
        @(posedge clk);
        #1;
        model_edge(rl, d, v, p);
        check("model", dut_vec(), model_vec());
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input logic pop_last);
        logic [7:0] sh;
        sh = b;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, sh[7:6], 1'b1, (i == 3) ? pop_last : 1'b0);
            sh = sh << 2;
            if (i < 3) for (int g = 0; g < gap; g++) step(1'b1, 2'b11, 1'b0, 1'b0);
        end
    endtask

    task automatic do_reset();
        step(1'b0, 2'b00, 1'b0, 1'b0);
        step(1'b0, 2'b00, 1'b0, 1'b0);
    endtask

    function automatic vec_t mk(input logic rl, input logic [1:0] d, input logic v, input logic p,
                                input logic [7:0] ed, input logic ev, input logic ef,
                                input logic ee, input logic eo);
        vec_t r;
        r.rl = rl; r.d = d; r.v = v; r.p = p;
        r.ed = ed; r.ev = ev; r.ef = ef; r.ee = ee; r.eo = eo;
        return r;
    endfunction

    initial begin
        reset_L  = 1'b0;
        data_in  = 2'b00;
        valid_in = 1'b0;
        pop      = 1'b0;

        // Basic packing, idle hold, pop, pop-when-empty, reset mid-byte.
        tbl[0]  = mk(0, 2'b00, 0, 0, 8'h00, 0, 0, 1, 0);
        tbl[1]  = mk(1, 2'b11, 1, 0, 8'h00, 0, 0, 1, 0);
        tbl[2]  = mk(1, 2'b00, 1, 0, 8'h00, 0, 0, 1, 0);
        tbl[3]  = mk(1, 2'b10, 1, 0, 8'h00, 0, 0, 1, 0);
        tbl[4]  = mk(1, 2'b01, 1, 0, 8'hC9, 1, 0, 0, 0);
        tbl[5]  = mk(1, 2'b10, 0, 0, 8'hC9, 1, 0, 0, 0);
        tbl[6]  = mk(1, 2'b00, 0, 1, 8'h00, 0, 0, 1, 0);
        tbl[7]  = mk(1, 2'b00, 0, 1, 8'h00, 0, 0, 1, 0);
        tbl[8]  = mk(1, 2'b11, 1, 0, 8'h00, 0, 0, 1, 0);
        tbl[9]  = mk(1, 2'b10, 1, 0, 8'h00, 0, 0, 1, 0);
        tbl[10] = mk(0, 2'b11, 1, 0, 8'h00, 0, 0, 1, 0);
        tbl[11] = mk(1, 2'b01, 1, 0, 8'h00, 0, 0, 1, 0);
        tbl[12] = mk(1, 2'b01, 1, 0, 8'h00, 0, 0, 1, 0);
        tbl[13] = mk(1, 2'b01, 1, 0, 8'h00, 0, 0, 1, 0);
        tbl[14] = mk(1, 2'b01, 1, 0, 8'h55, 1, 0, 0, 0);
        tbl[15] = mk(1, 2'b00, 0, 1, 8'h00, 0, 0, 1, 0);

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].rl, tbl[i].d, tbl[i].v, tbl[i].p);
            check($sformatf("table[%0d]", i),
                  {4'b0, data_out, valid_out, full, empty, overflow},
                  {4'b0, tbl[i].ed, tbl[i].ev, tbl[i].ef, tbl[i].ee, tbl[i].eo});
        end

        // Symbols separated by idle gaps form exactly one byte.
        do_reset();
        send_byte(8'hC9, 2, 1'b0);
        for (int g = 0; g < 3; g++) step(1'b1, 2'b10, 1'b0, 1'b0);
        check("gap_byte", {8'h0, data_out}, {8'h0, 8'hC9});
        step(1'b1, 2'b00, 1'b0, 1'b1);
        check("gap_count1", {15'h0, empty}, 16'h0001);

        // Fill to DEPTH, then drop a fifth byte.
        do_reset();
        for (int k = 1; k <= 4; k++) send_byte(8'(k), 0, 1'b0);
        check("full_after4", {14'h0, full, overflow}, 16'h0002);
        send_byte(8'h05, 0, 1'b0);
        check("ovf_after5", {14'h0, full, overflow}, 16'h0003);
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("ovf_read%0d", k), {8'h0, data_out}, {8'h0, 8'(k)});
            step(1'b1, 2'b00, 1'b0, 1'b1);
        end
        check("ovf_drained", {14'h0, empty, overflow}, 16'h0003);

        // Full FIFO accepts a byte when popped on the same edge.
        do_reset();
        for (int k = 1; k <= 4; k++) send_byte(8'(k), 0, 1'b0);
        send_byte(8'h05, 0, 1'b1);
        check("pushpop_full", {14'h0, full, overflow}, 16'h0002);
        for (int k = 2; k <= 5; k++) begin
            check($sformatf("pushpop_read%0d", k), {8'h0, data_out}, {8'h0, 8'(k)});
            step(1'b1, 2'b00, 1'b0, 1'b1);
        end
        check("pushpop_drained", {15'h0, empty}, 16'h0001);

`ifdef PARIDAD_EN
        do_reset();
        send_byte(8'h07, 0, 1'b0);
        send_byte(8'h03, 0, 1'b0);
        check("parity_07", {15'h0, parity_out}, 16'h0001);
        step(1'b1, 2'b00, 1'b0, 1'b1);
        check("parity_03", {15'h0, parity_out}, 16'h0000);
`endif

        // Random traffic with alternating pop pressure so the FIFO both drains and overflows.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            int unsigned pop_pct;
            pop_pct = ((c / 400) % 2 == 0) ? 8 : 60;
            step($urandom_range(0, 299) != 0,
                 2'($urandom_range(0, 3)),
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 99) < pop_pct);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/empaquetador_byte.md
EMPAQUETADOR_BYTE -- requirements
Module: empaquetador_byte

Interface
- REQ-001: Parameter DEPTH, default 4, SHALL set the number of byte entries in the output FIFO (power of two, 2..16).
- REQ-002: clk  input  1  SHALL be the single clock; all state updates on its rising edge.
- REQ-003: reset_L  input  1  SHALL be the synchronous, active-low reset, sampled on the rising edge of clk.
- REQ-004: data_in  input  2  SHALL carry one 2-bit symbol from the upstream mux-with-memory data_out.
- REQ-005: valid_in  input  1  SHALL qualify data_in; a symbol is accepted on every edge where valid_in=1 and reset_L=1.
- REQ-006: pop  input  1  SHALL request removal of the head byte.
- REQ-007: data_out  output  8  SHALL present the FIFO head byte (first-word fall-through).
- REQ-008: valid_out  output  1  SHALL be 1 when the FIFO holds at least one byte.
- REQ-009: full  output  1  SHALL be 1 when FIFO occupancy equals DEPTH.
- REQ-010: empty  output  1  SHALL be 1 when FIFO occupancy is 0.
- REQ-011: overflow  output  1  SHALL be a sticky flag indicating at least one completed byte was dropped.

Function
- REQ-012: Packing SHALL be MSB-first: 1st accepted symbol -> bits [7:6], 2nd -> [5:4], 3rd -> [3:2], 4th -> [1:0].
- REQ-013: FSM SHALL have two states: ESPERA (0 symbols held) and ACUMULA (1-3 symbols held); ESPERA->ACUMULA on an accepted symbol; ACUMULA->ESPERA on the 4th accepted symbol; otherwise hold.
- REQ-014: A 2-bit symbol counter SHALL increment per accepted symbol and wrap 3->0 on the 4th symbol; symbols with valid_in=0 SHALL be ignored, gaps of any length allowed.
- REQ-015: On the edge accepting the 4th symbol, the completed byte SHALL be written to the FIFO tail if not full, or if full and pop=1 in the same cycle.
- REQ-016: Latency: with FIFO empty, data_out and valid_out SHALL reflect the new byte on the cycle after the 4th symbol's edge.
- REQ-017: If FIFO full, pop=0, and a byte completes, the byte SHALL be dropped, FIFO contents unchanged, overflow set to 1 and held until reset; packing of the next byte SHALL continue normally.
- REQ-018: pop with valid_out=1 SHALL advance the head on that edge; pop while empty SHALL be ignored with no state change.
- REQ-019: Simultaneous push and pop SHALL keep occupancy unchanged and preserve FIFO order.
- REQ-020: When empty, data_out SHALL be 8'h00.
- REQ-021: Read/write pointers SHALL wrap modulo DEPTH; occupancy SHALL be tracked with a counter of width log2(DEPTH)+1.

Reset
- REQ-022: While reset_L=0 at an edge: FSM->ESPERA, symbol counter=0, partial byte=0, pointers and occupancy=0, overflow=0.
- REQ-023: Output reset values: data_out=8'h00, valid_out=0, full=0, empty=1, overflow=0 (and parity_out=0 when present).
- REQ-024: Reset asserted mid-byte or with FIFO non-empty SHALL discard all partial and stored data; symbols presented during reset SHALL not be accepted.

Configuration
- REQ-025: Macro PARIDAD_EN defined: each FIFO entry SHALL store a 9th bit equal to XOR of its 8 data bits, presented on extra output parity_out (1 bit) alongside data_out; 0 when empty.
- REQ-026: Macro PARIDAD_EN undefined: parity_out port and parity storage SHALL be absent; all other behaviour identical.

Verification
- REQ-027: Reset, then symbols 2'b11,2'b00,2'b10,2'b01 on consecutive cycles with valid_in=1 -> next cycle data_out=8'hC9, valid_out=1, empty=0.
- REQ-028: Same four symbols with valid_in=0 gaps of 2 cycles between each -> data_out=8'hC9, byte count 1, no extra bytes.
- REQ-029: DEPTH=4, push 5 bytes 8'h01..8'h05 with pop=0 -> full=1 after 4th, overflow=1 after 5th; then 4 pops read 8'h01..8'h04, empty=1.
- REQ-030: FIFO full, 5th byte completes with pop=1 same cycle -> overflow stays 0, occupancy stays 4, pops read 8'h02..8'h05.
- REQ-031: Two symbols accepted, then reset_L=0 for one cycle, then symbols 2'b01 x4 -> data_out=8'h55, no remnant of pre-reset symbols.
- REQ-032: PARIDAD_EN defined, bytes 8'h07 then 8'h03 -> parity_out=1 then 0 at head.
